// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams a wrapping address range of a single-port RAM
// out over valid/ready. Optional checksum: RAM_BURST_READER_CHECKSUM_EN.
module ram_burst_reader #(
    parameter int addr_width = 7,
    parameter int data_width = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [data_width-1:0] ram_dout,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef RAM_BURST_READER_CHECKSUM_EN
    output logic [data_width-1:0] checksum,
`endif
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);
    localparam logic [addr_width:0]   REM_ONE  = (addr_width + 1)'(1);

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [addr_width:0]     rem_q, rem_d;
    logic [data_width-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic start_ok;
    logic accept;
    logic capture;

    // busy covers the done cycle, so start is only taken once busy has dropped
    assign start_ok = (state_q == IDLE) && !busy_q && start;
    assign accept   = valid_q && m_ready;
    assign capture  = (state_q == READ) && (!valid_q || m_ready);

    // Next-state and datapath updates for the burst walker
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (done_q) begin
            busy_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (length != '0) begin
                        addr_d  = base_addr;
                        rem_d   = length;
                        busy_d  = 1'b1;
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (capture) begin
                    data_d  = ram_dout;
                    valid_d = 1'b1;
                    last_d  = (rem_q == REM_ONE);
                    addr_d  = addr_q + ADDR_ONE;
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [data_width-1:0] sum_q, sum_d;

    // Wrapping sum of accepted beats, cleared by each accepted start
    always_comb begin
        sum_d = sum_q;
        if (start_ok) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + data_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_addr = addr_q;
    assign ram_we   = 1'b0;
    assign m_data   = data_q;
    assign m_valid  = valid_q;
    assign m_last   = last_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: table-driven bursts with a beat scoreboard,
// plus hand sequences for backpressure, restart, zero length and reset.
module tb_ram_burst_reader;

    localparam int AW = 7;
    localparam int DW = 10;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_we, m_valid, m_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout, m_data;
`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] mem [DEPTH];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        bit            rnd;
        int            exp_done;
    } vec_t;

    beat_t sb[$];
    beat_t mon_b;
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic stall_q = 1'b0;
    logic [DW-1:0] stall_data = '0;

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    ram_burst_reader #(.addr_width(AW), .data_width(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
`ifdef RAM_BURST_READER_CHECKSUM_EN
        .checksum (checksum),
`endif
        .m_last   (m_last)
    );

    function automatic void chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endfunction

    // Beat monitor: scoreboard pop, hold-under-stall and last/valid rules
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (done) done_cnt++;
            chk("last_implies_valid", int'(m_last & ~m_valid), 0);
            if (stall_q) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_data", int'(m_data), int'(stall_data));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    mon_b = sb.pop_front();
                    chk("beat_data", int'(m_data), int'(mon_b.data));
                    chk("beat_last", int'(m_last), int'(mon_b.last));
                end
            end
            stall_q = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    task automatic push_beats(input logic [AW-1:0] b, input logic [AW:0] n,
                              output logic [DW-1:0] s);
        beat_t e;
        logic [AW-1:0] a;
        s = '0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            e.data = mem[a];
            e.last = (i == int'(n) - 1);
            sb.push_back(e);
            s = s + mem[a];
        end
    endtask

    task automatic wait_done(inout int cyc, output int dc);
        dc = -1;
        while (cyc < 600) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic post_check(input int d0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        @(posedge clk); #1;
        chk("done_once", done_cnt - d0, 1);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] n,
                             input bit rnd, input int exp_done);
        logic [DW-1:0] s;
        logic [AW-1:0] ea;
        int cyc, dc, d0;
        bit bad_busy, bad_addr;
        d0 = done_cnt;
        bad_busy = 0;
        bad_addr = 0;
        dc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        length = n;
        m_ready = 1'b1;
        push_beats(b, n, s);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 600) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (busy != (n != 0)) bad_busy = 1;
            if (!rnd && cyc <= int'(n)) begin
                ea = b + AW'(cyc - 1);
                if (ram_addr != ea) bad_addr = 1;
            end
            if (done) begin
                dc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b1;
        if (exp_done >= 0) chk("done_latency", dc, exp_done);
        else chk("done_seen", int'(dc >= 0), 1);
        chk("busy_trace", int'(bad_busy), 0);
        chk("addr_trace", int'(bad_addr), 0);
`ifdef RAM_BURST_READER_CHECKSUM_EN
        chk("checksum", int'(checksum), int'(s));
`endif
        post_check(d0);
    endtask

    vec_t vt[7];

    initial begin
        int cyc, dc, d0;
        logic [DW-1:0] s;

        vt[0] = '{base: 7'd5,   len: 8'd4,   rnd: 1'b0, exp_done: 6};
        vt[1] = '{base: 7'd126, len: 8'd3,   rnd: 1'b0, exp_done: 5};
        vt[2] = '{base: 7'd0,   len: 8'd1,   rnd: 1'b0, exp_done: 3};
        vt[3] = '{base: 7'd127, len: 8'd128, rnd: 1'b0, exp_done: 130};
        vt[4] = '{base: 7'd60,  len: 8'd7,   rnd: 1'b1, exp_done: -1};
        vt[5] = '{base: 7'd100, len: 8'd40,  rnd: 1'b1, exp_done: -1};
        vt[6] = '{base: 7'd10,  len: 8'd0,   rnd: 1'b0, exp_done: 1};

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_last", int'(m_last), 0);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_data", int'(m_data), 0);
`ifdef RAM_BURST_READER_CHECKSUM_EN
        chk("rst_checksum", int'(checksum), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_burst(vt[i].base, vt[i].len, vt[i].rnd, vt[i].exp_done);
        end

        // backpressure: first beat stalls for 4 cycles
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'd20; length = 8'd3; m_ready = 1'b0;
        push_beats(7'd20, 8'd3, s);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_valid", int'(m_valid), 1);
            chk("bp_data", int'(m_data), int'(mem[20]));
            chk("bp_last", int'(m_last), 0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        cyc = 6;
        wait_done(cyc, dc);
        chk("bp_done_latency", dc, 9);
        post_check(d0);

        // start again mid-burst with other parameters must be ignored
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'd30; length = 8'd6; m_ready = 1'b1;
        push_beats(7'd30, 8'd6, s);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'd90; length = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 4;
        wait_done(cyc, dc);
        chk("restart_done_latency", dc, 8);
        post_check(d0);

        // reset during the second beat of an 8-beat burst
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'd40; length = 8'd8; m_ready = 1'b1;
        push_beats(7'd40, 8'd8, s);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_data", int'(m_data), int'(mem[41]));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(m_valid), 0);
        chk("mid_rst_last", int'(m_last), 0);
        chk("mid_rst_data", int'(m_data), 0);
        chk("mid_rst_addr", int'(ram_addr), 0);
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_no_done", done_cnt - d0, 0);
        run_burst(7'd50, 8'd5, 1'b0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
